// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 16x-oversampling 8N1 UART receiver with first-word-fall-through
//           receive FIFO. Macro UART_RX_FRAME_CHECK_EN enables stop-bit checking.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_enable,
    input  logic [15:0]                   i_baud_div,
    input  logic                          i_rx,
    input  logic                          i_read,
    input  logic                          i_clear_err,
    output logic [7:0]                    o_data,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_active,
    output logic                          o_overrun,
    output logic                          o_frame_err
);

    localparam int                c_ADDR_W     = $clog2(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0] c_FULL_COUNT = FIFO_DEPTH[c_ADDR_W:0];

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    logic                r_rx_meta;
    logic                r_rx_sync;
    logic [15:0]         r_baud_cnt;
    logic                r_tick;
    state_t              r_state;
    logic [3:0]          r_sample_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_active;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic                r_overrun;

    logic w_stop_tick;
    logic w_push;
    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_baud_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_baud_cnt >= i_baud_div) begin
            r_baud_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
            r_tick     <= 1'b0;
        end
    end

    // Start bit is re-checked at mid-bit (count 7); data/stop then sample every 16 ticks.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_active     <= 1'b0;
        end else if (!i_enable) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_active     <= 1'b0;
        end else if (r_tick) begin
            case (r_state)
                IDLE: begin
                    if (!r_rx_sync) begin
                        r_sample_cnt <= '0;
                        r_bit_cnt    <= '0;
                        r_state      <= START_BIT;
                        r_active     <= 1'b1;
                    end
                end
                START_BIT: begin
                    if (r_sample_cnt == 4'd7) begin
                        r_sample_cnt <= '0;
                        if (!r_rx_sync) begin
                            r_state <= DATA_BITS;
                        end else begin
                            r_state  <= IDLE;
                            r_active <= 1'b0;
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt + 4'd1;
                    end
                end
                DATA_BITS: begin
                    r_sample_cnt <= r_sample_cnt + 4'd1;
                    if (r_sample_cnt == 4'd15) begin
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP_BIT;
                        end
                    end
                end
                STOP_BIT: begin
                    r_sample_cnt <= r_sample_cnt + 4'd1;
                    if (r_sample_cnt == 4'd15) begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign w_stop_tick = i_enable && r_tick && (r_state == STOP_BIT) && (r_sample_cnt == 4'd15);

`ifdef UART_RX_FRAME_CHECK_EN
    logic w_frame_set;
    logic r_frame_err;

    assign w_push      = w_stop_tick & r_rx_sync;
    assign w_frame_set = w_stop_tick & ~r_rx_sync;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_frame_err <= 1'b0;
        end else if (w_frame_set) begin
            r_frame_err <= 1'b1;
        end else if (i_clear_err) begin
            r_frame_err <= 1'b0;
        end
    end

    assign o_frame_err = r_frame_err;
`else
    assign w_push      = w_stop_tick;
    assign o_frame_err = 1'b0;
`endif

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);
    // A push into a full FIFO is dropped even when a pop happens in the same cycle.
    assign w_wr    = w_push & ~w_full;
    assign w_rd    = i_read & ~w_empty;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (c_ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_overrun <= 1'b0;
        end else if (w_push && w_full) begin
            r_overrun <= 1'b1;
        end else if (i_clear_err) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_data    = r_mem[r_rd_ptr];
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_count   = r_count;
    assign o_active  = r_active;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : directed stimulus for uart_rx with a queue-based read scoreboard.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] baud_div;
    logic        rx;
    logic        read;
    logic        clear_err;
    logic [7:0]  data;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        active;
    logic        overrun;
    logic        frame_err;

    int          n_vec = 0;
    int          n_err = 0;
    int          bit_clks;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;
    int          lat_c;
    bit          lat_seen;

    always #5 clk = ~clk;

    uart_rx #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_enable    (enable),
        .i_baud_div  (baud_div),
        .i_rx        (rx),
        .i_read      (read),
        .i_clear_err (clear_err),
        .o_data      (data),
        .o_empty     (empty),
        .o_full      (full),
        .o_count     (count),
        .o_active    (active),
        .o_overrun   (overrun),
        .o_frame_err (frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Read monitor: every accepted pop is checked against the oldest expected byte.
    always @(negedge clk) begin
        if (reset_n && read && !empty) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got %0h, expected no byte", data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_data", 32'(data), 32'(mon_exp));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        cyc(bit_clks);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(bit_clks);
        end
        rx = stop_bit;
        cyc(bit_clks);
        rx = 1'b1;
        cyc(2 * bit_clks);
    endtask

    task automatic read_one();
        read = 1'b1;
        cyc(1);
        read = 1'b0;
    endtask

    task automatic clear_pulse();
        clear_err = 1'b1;
        cyc(1);
        clear_err = 1'b0;
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    initial begin
        #1_000_000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        summary();
        $finish;
    end

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        rx        = 1'b1;
        read      = 1'b0;
        clear_err = 1'b0;
        baud_div  = 16'd0;
        bit_clks  = 16;
        cyc(3);

        @(negedge clk);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_full",      32'(full),      32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_data",      32'(data),      32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_active",    32'(active),    32'd0);
        cyc(1);
        reset_n = 1'b1;
        cyc(4);

        // 0xA5 at 16 clk/bit: byte must land within 160 clocks of the start edge.
        exp_q.push_back(8'hA5);
        lat_c    = 0;
        lat_seen = 1'b0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (!lat_seen && lat_c < 200) begin
                    @(posedge clk);
                    #1;
                    lat_c++;
                    if (!empty) lat_seen = 1'b1;
                end
                chk("a5_latency_le160", 32'(lat_seen && lat_c <= 160), 32'd1);
            end
        join
        @(negedge clk);
        chk("a5_data",      32'(data),      32'hA5);
        chk("a5_count",     32'(count),     32'd1);
        chk("a5_frame_err", 32'(frame_err), 32'd0);
        cyc(1);
        read_one();
        @(negedge clk);
        chk("a5_empty_after_read", 32'(empty), 32'd1);
        cyc(1);

        read_one();
        @(negedge clk);
        chk("read_while_empty_count", 32'(count), 32'd0);
        cyc(1);

        // One-clock low glitch: start detected, rejected at mid-bit.
        rx = 1'b0;
        cyc(1);
        rx = 1'b1;
        cyc(4);
        @(negedge clk);
        chk("glitch_active_seen", 32'(active), 32'd1);
        cyc(30);
        @(negedge clk);
        chk("glitch_idle",  32'(active), 32'd0);
        chk("glitch_empty", 32'(empty),  32'd1);
        cyc(1);

`ifdef UART_RX_FRAME_CHECK_EN
        send_byte(8'h3C, 1'b0);
        @(negedge clk);
        chk("frame_err_set",  32'(frame_err), 32'd1);
        chk("frame_no_push",  32'(empty),     32'd1);
`else
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b0);
        @(negedge clk);
        chk("frame_err_tied", 32'(frame_err), 32'd0);
        chk("frame_pushed",   32'(count),     32'd1);
        chk("frame_data",     32'(data),      32'h3C);
        cyc(1);
        read_one();
`endif
        cyc(1);
        clear_pulse();
        @(negedge clk);
        chk("frame_err_cleared", 32'(frame_err), 32'd0);
        cyc(1);

        // Nine bytes into an 8-deep FIFO: the ninth is dropped and flagged.
        for (int b = 0; b < 9; b++) begin
            if (b < FIFO_DEPTH) exp_q.push_back(8'(b));
            send_byte(8'(b), 1'b1);
        end
        @(negedge clk);
        chk("ovf_full",    32'(full),    32'd1);
        chk("ovf_overrun", 32'(overrun), 32'd1);
        chk("ovf_count",   32'(count),   32'd8);
        chk("ovf_head",    32'(data),    32'h00);
        cyc(1);
        clear_pulse();
        @(negedge clk);
        chk("ovf_cleared", 32'(overrun), 32'd0);
        cyc(1);
        repeat (FIFO_DEPTH) read_one();
        @(negedge clk);
        chk("ovf_drained",    32'(empty),         32'd1);
        chk("ovf_queue_done", 32'(exp_q.size()),  32'd0);
        cyc(1);

        // Enable dropped mid-byte with two bytes queued.
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        exp_q.push_back(8'h22);
        send_byte(8'h22, 1'b1);
        fork
            send_byte(8'h77, 1'b1);
            begin
                cyc(5 * bit_clks);
                enable = 1'b0;
                cyc(1);
                @(negedge clk);
                chk("en_active_low", 32'(active), 32'd0);
                chk("en_count_kept", 32'(count),  32'd2);
            end
        join
        @(negedge clk);
        chk("en_no_partial_push", 32'(count), 32'd2);
        cyc(1);
        read_one();
        read_one();
        @(negedge clk);
        chk("en_read_drained", 32'(empty), 32'd1);
        cyc(1);
        enable = 1'b1;
        cyc(4);

        // Reset in the middle of data bit 3 at 64 clk/bit, then a clean 0x5A.
        baud_div = 16'd3;
        bit_clks = 64;
        cyc(20);
        fork
            send_byte(8'hF8, 1'b1);
            begin
                cyc(bit_clks + 3 * bit_clks + bit_clks / 2);
                reset_n = 1'b0;
                cyc(3);
                @(negedge clk);
                chk("midrst_active", 32'(active), 32'd0);
                chk("midrst_count",  32'(count),  32'd0);
                cyc(1);
                reset_n = 1'b1;
            end
        join
        @(negedge clk);
        chk("midrst_no_push", 32'(empty), 32'd1);
        cyc(1);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        @(negedge clk);
        chk("midrst_5a_count", 32'(count), 32'd1);
        chk("midrst_5a_data",  32'(data),  32'h5A);
        cyc(1);
        read_one();
        @(negedge clk);
        chk("final_empty",      32'(empty),        32'd1);
        chk("final_queue_done", 32'(exp_q.size()), 32'd0);

        summary();
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO depth in bytes; power of two, minimum 2.
REQ-002 SHALL have port i_clk, input, 1, system clock.
REQ-003 SHALL have port i_reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_enable, input, 1, receiver enable.
REQ-005 SHALL have port i_baud_div, input, 16, baud divisor; baud = i_clk / (16 * (i_baud_div + 1)).
REQ-006 SHALL have port i_rx, input, 1, asynchronous serial line, idle high.
REQ-007 SHALL have port i_read, input, 1, pop FIFO head.
REQ-008 SHALL have port i_clear_err, input, 1, clear sticky error flags.
REQ-009 SHALL have port o_data, output, 8, FIFO head byte; valid while o_empty is low.
REQ-010 SHALL have port o_empty, output, 1, FIFO empty.
REQ-011 SHALL have port o_full, output, 1, FIFO full.
REQ-012 SHALL have port o_count, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-013 SHALL have port o_active, output, 1, high while state is not IDLE.
REQ-014 SHALL have port o_overrun, output, 1, sticky: a byte was dropped because the FIFO was full.
REQ-015 SHALL have port o_frame_err, output, 1, sticky: a stop bit was sampled low.

Function
REQ-016 SHALL pass i_rx through a 2-flop synchronizer, reset value 1; all sampling uses the synchronized value.
REQ-017 SHALL run a free-running 16-bit baud counter: when counter >= i_baud_div, counter clears and a 1-cycle tick pulses; otherwise counter increments; the tick is registered.
REQ-018 SHALL use a 4-bit sample counter advanced once per tick; one bit period is 16 ticks.
REQ-019 SHALL implement states IDLE, START_BIT, DATA_BITS, STOP_BIT.
REQ-020 IDLE: on a tick with synchronized rx low, SHALL clear the sample counter and enter START_BIT.
REQ-021 START_BIT: on the tick where sample count == 7 (mid-bit), SHALL clear the sample counter and enter DATA_BITS if rx is low, else return to IDLE (glitch rejection, nothing stored).
REQ-022 DATA_BITS: on each tick where sample count == 15, SHALL shift rx into the data register LSB first; after the 8th bit it SHALL enter STOP_BIT.
REQ-023 STOP_BIT: on the tick where sample count == 15, SHALL evaluate the stop bit, push or discard the byte per REQ-024 to REQ-026 and REQ-034, then enter IDLE.
REQ-024 A push SHALL occur in the cycle of the stop-bit tick; o_empty SHALL fall and o_data SHALL show the byte on the following cycle when the FIFO was empty.
REQ-025 The FIFO SHALL be first-word-fall-through: i_read while not empty pops the head in one cycle; i_read while empty SHALL be ignored.
REQ-026 If o_full is high in the push cycle, the byte SHALL be dropped and o_overrun set, even if i_read is asserted in the same cycle.
REQ-027 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave o_count unchanged.
REQ-028 o_overrun and o_frame_err SHALL clear on i_clear_err; a set event in the same cycle SHALL win over the clear.
REQ-029 Pointer wrap at FIFO_DEPTH SHALL be seamless; o_count SHALL range 0 to FIFO_DEPTH.
REQ-030 i_enable low SHALL force IDLE and clear the sample counter, discarding any partial byte; FIFO contents and error flags SHALL be retained and reads SHALL still work.

Reset
REQ-031 Asynchronous reset SHALL set state IDLE, all counters 0, synchronizer flops 1, FIFO empty (o_empty=1, o_full=0, o_count=0), o_data=0, o_overrun=0, o_frame_err=0, o_active=0.
REQ-032 Reset asserted mid-byte SHALL discard the partial byte; no push SHALL occur after release until a new start bit is seen.

Configuration
REQ-033 Macro UART_RX_FRAME_CHECK_EN SHALL control stop-bit checking.
REQ-034 With UART_RX_FRAME_CHECK_EN defined: a stop bit sampled low SHALL discard the byte and set o_frame_err. Without it: the byte SHALL be pushed regardless of stop-bit value and o_frame_err SHALL be tied 0.

Verification
REQ-035 i_baud_div=0, serial 0xA5 8N1 (16 clk/bit) -> o_empty falls within 160 clk of the start edge, o_data=0xA5, o_count=1, o_frame_err=0.
REQ-036 1-tick-wide low pulse on idle line -> return to IDLE, o_empty stays 1.
REQ-037 FIFO_DEPTH=8, send 9 bytes 0x00..0x08 with no reads -> o_full=1, o_overrun=1, reads return 0x00..0x07 in order; i_clear_err clears o_overrun.
REQ-038 Send 0x3C with stop bit low -> with macro: no push, o_frame_err=1; without macro: o_data=0x3C pushed, o_frame_err=0.
REQ-039 i_baud_div=3, assert i_reset_n low during the 4th data bit, release, then send 0x5A -> only 0x5A appears in the FIFO.
REQ-040 Drop i_enable mid-byte with 2 bytes queued -> o_active=0, o_count=2 retained, queued bytes readable.
